// File: rtl/ms_control_unit_pkg.sv
// rtl/ms_control_unit_pkg.sv - opcode, condition, state and datapath-select encodings
// Shared with the msprocessor datapath so both sides agree on every mux code.
package ms_control_unit_pkg;

   typedef enum logic [3:0] {
      S_IDLE   = 4'd0,
      S_FETCH  = 4'd1,
      S_DECODE = 4'd2,
      S_EXEC   = 4'd3,
      S_ALUWB  = 4'd4,
      S_MEMADR = 4'd5,
      S_MEMRD  = 4'd6,
      S_MEMWB  = 4'd7,
      S_MEMWR  = 4'd8,
      S_BRANCH = 4'd9,
      S_HALT   = 4'd10
   } state_t;

   localparam logic [3:0] OP_NOP   = 4'h0;
   localparam logic [3:0] OP_ADD   = 4'h1;
   localparam logic [3:0] OP_SUB   = 4'h2;
   localparam logic [3:0] OP_AND   = 4'h3;
   localparam logic [3:0] OP_ORR   = 4'h4;
   localparam logic [3:0] OP_CMP   = 4'h5;
   localparam logic [3:0] OP_MOV   = 4'h6;
   localparam logic [3:0] OP_SHIFT = 4'h7;
   localparam logic [3:0] OP_LDR   = 4'h8;
   localparam logic [3:0] OP_STR   = 4'h9;
   localparam logic [3:0] OP_B     = 4'hA;
   localparam logic [3:0] OP_HALT  = 4'hF;

   localparam logic [3:0] COND_EQ = 4'h0;
   localparam logic [3:0] COND_NE = 4'h1;
   localparam logic [3:0] COND_CS = 4'h2;
   localparam logic [3:0] COND_CC = 4'h3;
   localparam logic [3:0] COND_MI = 4'h4;
   localparam logic [3:0] COND_PL = 4'h5;
   localparam logic [3:0] COND_VS = 4'h6;
   localparam logic [3:0] COND_VC = 4'h7;
   localparam logic [3:0] COND_GE = 4'h8;
   localparam logic [3:0] COND_LT = 4'h9;
   localparam logic [3:0] COND_AL = 4'hE;

   localparam logic [2:0] ALU_ADD   = 3'd0;
   localparam logic [2:0] ALU_SUB   = 3'd1;
   localparam logic [2:0] ALU_AND   = 3'd2;
   localparam logic [2:0] ALU_ORR   = 3'd3;
   localparam logic [2:0] ALU_PASSB = 3'd4;

   localparam logic [1:0] SRCB_RD2  = 2'd0;
   localparam logic [1:0] SRCB_IMM4 = 2'd1;
   localparam logic [1:0] SRCB_IMM8 = 2'd2;

   localparam logic [1:0] RES_ALU   = 2'd0;
   localparam logic [1:0] RES_MEM   = 2'd1;
   localparam logic [1:0] RES_SHIFT = 2'd2;

   // Opcodes B..E are unassigned.
   function automatic logic op_illegal(input logic [3:0] op);
      return (op >= 4'hB) && (op <= 4'hE);
   endfunction

endpackage

// File: rtl/ms_control_unit_if.sv
// rtl/ms_control_unit_if.sv - control unit <-> datapath bundle
// master = control unit (drives enables/selects), slave = datapath (drives IR and flags).
interface ms_control_unit_if #(
   parameter int CNT_W = 16
);
   logic             RUN;
   logic [15:0]      INSTR;
   logic             C, Z, N, V;
   logic             PCWrite, PCSrc, IRWrite, AdrSrc, MemWrite, RegWrite;
   logic [1:0]       ALUSrcB;
   logic [2:0]       ALUControl;
   logic [1:0]       ResultSrc;
   logic [1:0]       ShiftCtl;
   logic             FlagWrite;
   logic [3:0]       STATE;
   logic             HALTED;
   logic             ILLEGAL;
   logic [CNT_W-1:0] RETIRED;

   modport master (
      input  RUN, INSTR, C, Z, N, V,
      output PCWrite, PCSrc, IRWrite, AdrSrc, MemWrite, RegWrite, ALUSrcB,
             ALUControl, ResultSrc, ShiftCtl, FlagWrite, STATE, HALTED, ILLEGAL, RETIRED
   );

   modport slave (
      output RUN, INSTR, C, Z, N, V,
      input  PCWrite, PCSrc, IRWrite, AdrSrc, MemWrite, RegWrite, ALUSrcB,
             ALUControl, ResultSrc, ShiftCtl, FlagWrite, STATE, HALTED, ILLEGAL, RETIRED
   );
endinterface

// File: rtl/ms_cond_check.sv
// rtl/ms_cond_check.sv - branch condition evaluation on the current flags
module ms_cond_check
   import ms_control_unit_pkg::*;
(
   input  logic [3:0] cond,
   input  logic       C,
   input  logic       Z,
   input  logic       N,
   input  logic       V,
   output logic       cond_ok
);
   always_comb begin
      cond_ok = 1'b0;
      case (cond)
         COND_EQ: cond_ok = Z;
         COND_NE: cond_ok = !Z;
         COND_CS: cond_ok = C;
         COND_CC: cond_ok = !C;
         COND_MI: cond_ok = N;
         COND_PL: cond_ok = !N;
         COND_VS: cond_ok = V;
         COND_VC: cond_ok = !V;
         COND_GE: cond_ok = (N == V);
         COND_LT: cond_ok = (N != V);
         COND_AL: cond_ok = 1'b1;
         default: cond_ok = 1'b0;
      endcase
   end
endmodule

// File: rtl/ms_control_unit.sv
// rtl/ms_control_unit.sv - multi-cycle sequencer for the 8-bit msprocessor datapath
// Outputs are a Moore decode of the state register plus the (stable) IR contents.
module ms_control_unit
   import ms_control_unit_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic                clk,
   input  logic                RESET_N,
   ms_control_unit_if.master   bus
);
   state_t           state;
   logic [CNT_W-1:0] retired;
   logic [3:0]       op;
   logic             cond_ok;
   logic             done;
   logic             retire;
   logic             unused_instr;

   assign op           = bus.INSTR[15:12];
   assign unused_instr = ^{bus.INSTR[7:6], bus.INSTR[3:0]};

   ms_cond_check u_cond (
      .cond    (bus.INSTR[11:8]),
      .C       (bus.C),
      .Z       (bus.Z),
      .N       (bus.N),
      .V       (bus.V),
      .cond_ok (cond_ok)
   );

   // Instruction boundary: RUN is only ever sampled here and in IDLE.
   always_comb begin
      done   = 1'b0;
      retire = 1'b0;
      case (state)
         S_DECODE: begin
            done   = (op == OP_NOP) || op_illegal(op);
            retire = (op == OP_NOP);
         end
         S_EXEC: begin
            done   = (op == OP_CMP);
            retire = (op == OP_CMP);
         end
         S_ALUWB, S_MEMWB, S_MEMWR, S_BRANCH: begin
            done   = 1'b1;
            retire = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge RESET_N) begin
      if (!RESET_N) begin
         state   <= S_IDLE;
         retired <= '0;
      end else begin
         if (retire)
            retired <= retired + CNT_W'(1);
         if (done) begin
            state <= bus.RUN ? S_FETCH : S_IDLE;
         end else begin
            case (state)
               S_IDLE:   if (bus.RUN) state <= S_FETCH;
               S_FETCH:  state <= S_DECODE;
               S_DECODE: begin
                  if (op >= OP_ADD && op <= OP_SHIFT)    state <= S_EXEC;
                  else if (op == OP_LDR || op == OP_STR) state <= S_MEMADR;
                  else if (op == OP_B)                   state <= S_BRANCH;
                  else if (op == OP_HALT)                state <= S_HALT;
               end
               S_EXEC:   state <= S_ALUWB;
               S_MEMADR: state <= (op == OP_LDR) ? S_MEMRD : S_MEMWR;
               S_MEMRD:  state <= S_MEMWB;
               S_HALT:   state <= S_HALT;
               default:  state <= S_IDLE;
            endcase
         end
      end
   end

   always_comb begin
      bus.PCWrite    = 1'b0;
      bus.PCSrc      = 1'b0;
      bus.IRWrite    = 1'b0;
      bus.AdrSrc     = 1'b0;
      bus.MemWrite   = 1'b0;
      bus.RegWrite   = 1'b0;
      bus.ALUSrcB    = SRCB_RD2;
      bus.ALUControl = ALU_ADD;
      bus.ResultSrc  = RES_ALU;
      bus.ShiftCtl   = 2'd0;
      bus.FlagWrite  = 1'b0;
      bus.HALTED     = 1'b0;
      bus.ILLEGAL    = 1'b0;
      case (state)
         S_FETCH: begin
            bus.IRWrite = 1'b1;
            bus.PCWrite = 1'b1;
         end
         S_DECODE: bus.ILLEGAL = op_illegal(op);
         S_EXEC: begin
            bus.ShiftCtl  = bus.INSTR[5:4];
            bus.FlagWrite = (op >= OP_ADD) && (op <= OP_CMP);
            case (op)
               OP_SUB, OP_CMP: bus.ALUControl = ALU_SUB;
               OP_AND:         bus.ALUControl = ALU_AND;
               OP_ORR:         bus.ALUControl = ALU_ORR;
               OP_MOV: begin
                  bus.ALUControl = ALU_PASSB;
                  bus.ALUSrcB    = SRCB_IMM8;
               end
               OP_SHIFT:       bus.ResultSrc = RES_SHIFT;
               default:        bus.ALUControl = ALU_ADD;
            endcase
         end
         // Shift results bypass the ALU, so the write-back mux must keep selecting them.
         S_ALUWB: begin
            bus.RegWrite  = 1'b1;
            bus.ResultSrc = (op == OP_SHIFT) ? RES_SHIFT : RES_ALU;
         end
         S_MEMADR: bus.ALUSrcB = SRCB_IMM4;
         S_MEMRD:  bus.AdrSrc  = 1'b1;
         S_MEMWB: begin
            bus.RegWrite  = 1'b1;
            bus.ResultSrc = RES_MEM;
         end
         S_MEMWR: begin
            bus.AdrSrc   = 1'b1;
            bus.MemWrite = 1'b1;
         end
         S_BRANCH: begin
            bus.ALUSrcB = SRCB_IMM8;
            bus.PCSrc   = 1'b1;
            bus.PCWrite = cond_ok;
         end
         S_HALT:   bus.HALTED = 1'b1;
         default: ;
      endcase
   end

   assign bus.STATE   = state;
   assign bus.RETIRED = retired;

endmodule
